// File: rtl/layer_norm_forward_if.sv
// Handshake and data bundle between a layer-norm forward engine and its requester/consumer.
// master drives the request side (vector, count, affine params, handshakes); slave is the engine.
interface layer_norm_forward_if #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int SIZE = 16
);
    localparam int W = IL + FL;

    logic [W-1:0] batch [SIZE];
    logic [3:0]   num;
    logic [W-1:0] gamma;
    logic [W-1:0] beta;
    logic         input_ready;
    logic         output_taken;
    logic [W-1:0] out  [SIZE];
    logic [W-1:0] norm [SIZE];
    logic [W-1:0] mu;
    logic [W-1:0] vari;
    logic [1:0]   state;
    logic         done;

    modport master (
        output batch, num, gamma, beta, input_ready, output_taken,
        input  out, norm, mu, vari, state, done
    );

    modport slave (
        input  batch, num, gamma, beta, input_ready, output_taken,
        output out, norm, mu, vari, state, done
    );
endinterface

// File: rtl/layer_norm_forward.sv
// Layer-norm forward: mean, variance, bitwise sqrt, reciprocal, then per-lane norm and gamma/beta affine.
// Latency 3*num+IL+FL+3 cycles (1 if num==0); holds results in DONE until output_taken, ignores requests while busy.
module layer_norm_forward #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int SIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    layer_norm_forward_if.slave bus
);
    localparam int W  = IL + FL;
    localparam int AW = W + 4;
    localparam int RW = W + 4;
    localparam logic signed [63:0] MAXV = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam logic signed [63:0] MINV = -(64'sd1 <<< (W - 1));

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10} state_e;
    typedef enum logic [2:0] {P_MEAN, P_MDIV, P_VAR, P_VDIV, P_SQRT, P_RECIP, P_NORM} phase_e;

    state_e         state_q;
    phase_e         phase_q;
    logic [4:0]     cnt_q;
    logic           done_q;
    logic [W-1:0]   x_q [SIZE];
    logic [3:0]     num_q;
    logic [W-1:0]   gamma_q;
    logic [W-1:0]   beta_q;
    logic [AW-1:0]  acc_q;
    logic [W-1:0]   mu_q;
    logic [W-1:0]   vari_q;
    logic [2*W-1:0] rad_q;
    logic [RW-1:0]  rem_q;
    logic [W-1:0]   root_q;
    logic [2*W-1:0] sinv_q;
    logic [W-1:0]   norm_q [SIZE];
    logic [W-1:0]   out_q  [SIZE];

    function automatic logic [W-1:0] sat(input logic signed [63:0] v);
        if (v > MAXV)      sat = MAXV[W-1:0];
        else if (v < MINV) sat = MINV[W-1:0];
        else               sat = v[W-1:0];
    endfunction

    function automatic logic signed [63:0] sx(input logic [W-1:0] v);
        sx = {{(64-W){v[W-1]}}, v};
    endfunction

    logic [3:0]         idx;
    logic               last;
    logic signed [63:0] diff_d;
    logic signed [63:0] sq_d;
    logic signed [AW-1:0] acc_s;
    logic signed [AW-1:0] num_s;
    logic signed [AW-1:0] quot_d;
    logic [W-1:0]       mu_d;
    logic [W-1:0]       vari_d;
    logic [63:0]        vplus_d;
    logic [RW-1:0]      rem_sh;
    logic [RW-1:0]      trial;
    logic [RW-1:0]      rem_d;
    logic [W-1:0]       root_d;
    logic [63:0]        sinv_w;
    logic signed [63:0] nprod_d;
    logic signed [63:0] oval_d;
    logic [W-1:0]       norm_d;
    logic [W-1:0]       out_d;

    always_comb begin
        idx     = cnt_q[3:0];
        last    = (cnt_q == ({1'b0, num_q} - 5'd1));
        diff_d  = sx(x_q[idx]) - sx(mu_q);
        sq_d    = (diff_d * diff_d) >>> FL;
        acc_s   = acc_q;
        // num==0 never reaches a divide phase; the guard only keeps the divider defined
        num_s   = (num_q == 4'd0) ? AW'(1) : AW'(num_q);
        quot_d  = acc_s / num_s;
        mu_d    = quot_d[W-1:0];
        vari_d  = sat({{(64-AW){quot_d[AW-1]}}, quot_d});
        vplus_d = (sx(vari_d) + 64'sd1) <<< FL;

        rem_sh  = {rem_q[RW-3:0], rad_q[2*W-1 -: 2]};
        trial   = RW'({root_q, 2'b01});
        rem_d   = rem_sh;
        root_d  = {root_q[W-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {root_q[W-2:0], 1'b1};
        end

        sinv_w  = (64'd1 << (2 * FL)) / ({{(64-W){1'b0}}, root_q} + 64'd1);
        nprod_d = diff_d * $signed({{(64-2*W){1'b0}}, sinv_q});
        norm_d  = sat(nprod_d >>> FL);
        oval_d  = ((sx(norm_d) * sx(gamma_q)) >>> FL) + sx(beta_q);
        out_d   = sat(oval_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= P_MEAN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            num_q   <= '0;
            gamma_q <= '0;
            beta_q  <= '0;
            acc_q   <= '0;
            mu_q    <= '0;
            vari_q  <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            sinv_q  <= '0;
            for (int i = 0; i < SIZE; i++) begin
                x_q[i]    <= '0;
                norm_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.input_ready) begin
                        for (int i = 0; i < SIZE; i++) begin
                            x_q[i]    <= bus.batch[i];
                            norm_q[i] <= '0;
                            out_q[i]  <= '0;
                        end
                        num_q   <= bus.num;
                        gamma_q <= bus.gamma;
                        beta_q  <= bus.beta;
                        acc_q   <= '0;
                        mu_q    <= '0;
                        vari_q  <= '0;
                        cnt_q   <= '0;
                        phase_q <= P_MEAN;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    case (phase_q)
                        P_MEAN: begin
                            if (num_q == 4'd0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                acc_q <= acc_q + {{(AW-W){x_q[idx][W-1]}}, x_q[idx]};
                                if (last) begin
                                    cnt_q   <= '0;
                                    phase_q <= P_MDIV;
                                end else begin
                                    cnt_q <= cnt_q + 5'd1;
                                end
                            end
                        end
                        P_MDIV: begin
                            mu_q    <= mu_d;
                            acc_q   <= '0;
                            phase_q <= P_VAR;
                        end
                        P_VAR: begin
                            acc_q <= acc_q + sq_d[AW-1:0];
                            if (last) begin
                                cnt_q   <= '0;
                                phase_q <= P_VDIV;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                        P_VDIV: begin
                            vari_q  <= vari_d;
                            rad_q   <= vplus_d[2*W-1:0];
                            rem_q   <= '0;
                            root_q  <= '0;
                            cnt_q   <= '0;
                            phase_q <= P_SQRT;
                        end
                        P_SQRT: begin
                            rad_q  <= rad_q << 2;
                            rem_q  <= rem_d;
                            root_q <= root_d;
                            if (cnt_q == 5'(W - 1)) begin
                                cnt_q   <= '0;
                                phase_q <= P_RECIP;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                        P_RECIP: begin
                            sinv_q  <= sinv_w[2*W-1:0];
                            phase_q <= P_NORM;
                        end
                        P_NORM: begin
                            norm_q[idx] <= norm_d;
                            out_q[idx]  <= out_d;
                            if (last) begin
                                cnt_q   <= '0;
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                        default: phase_q <= P_MEAN;
                    endcase
                end
                S_DONE: begin
                    if (bus.output_taken) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.state = state_q;
    assign bus.done  = done_q;
    assign bus.mu    = mu_q;
    assign bus.vari  = vari_q;

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        assign bus.norm[g] = norm_q[g];
        assign bus.out[g]  = out_q[g];
    end
endmodule

// File: tb/tb_layer_norm_forward.sv
// Randomised and directed bench for layer_norm_forward against a plain-arithmetic layer-norm model.
module tb_layer_norm_forward;
    localparam int IL = 4, FL = 16, SIZE = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    layer_norm_forward_if #(.IL(IL), .FL(FL), .SIZE(SIZE)) bus ();
    layer_norm_forward #(.IL(IL), .FL(FL), .SIZE(SIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    bit     exp_valid = 1'b0;
    longint exp_mu, exp_vari;
    longint exp_norm [SIZE];
    longint exp_out  [SIZE];
    longint xv [SIZE];
    int     tn;
    longint tg, tbeta;

    function automatic longint sat(input longint v);
        if (v > 524287)  return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    function automatic longint s20(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: straight from the formulas, with exact integer square root.
    task automatic model();
        longint sum, vsum, r, rad, sinv, d;
        exp_mu = 0;
        exp_vari = 0;
        for (int i = 0; i < SIZE; i++) begin
            exp_norm[i] = 0;
            exp_out[i]  = 0;
        end
        if (tn == 0) return;
        sum = 0;
        for (int i = 0; i < tn; i++) sum += xv[i];
        exp_mu = sum / tn;
        vsum = 0;
        for (int i = 0; i < tn; i++) begin
            d = xv[i] - exp_mu;
            vsum += (d * d) >>> FL;
        end
        exp_vari = sat(vsum / tn);
        rad = (exp_vari + 1) <<< FL;
        r = longint'($sqrt(real'(rad)));
        while (r * r > rad) r--;
        while ((r + 1) * (r + 1) <= rad) r++;
        sinv = (longint'(1) <<< (2 * FL)) / (r + 1);
        for (int i = 0; i < tn; i++) begin
            d = xv[i] - exp_mu;
            exp_norm[i] = sat((d * sinv) >>> FL);
            exp_out[i]  = sat(((exp_norm[i] * tg) >>> FL) + tbeta);
        end
    endtask

    task automatic load();
        for (int i = 0; i < SIZE; i++) bus.batch[i] = xv[i][19:0];
        bus.num   = 4'(tn);
        bus.gamma = tg[19:0];
        bus.beta  = tbeta[19:0];
        model();
    endtask

    task automatic clear_vec();
        for (int i = 0; i < SIZE; i++) xv[i] = 0;
    endtask

    task automatic run_job(input int lat_exp, input bit toggle, input int hold);
        int n;
        int w;
        w = 0;
        while (bus.state != 2'b00 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        load();
        exp_valid = 1'b1;
        bus.input_ready = 1'b1;
        @(posedge clk); #1;
        bus.input_ready = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus.state == 2'b10) break;
            if (toggle) bus.input_ready = 1'($urandom_range(0, 1));
        end
        bus.input_ready = 1'b0;
        chk("latency", n, lat_exp);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic release_job();
        bus.output_taken = 1'b1;
        @(posedge clk); #1;
        bus.output_taken = 1'b0;
        chk("idle_after_take", bus.state, 0);
        chk("done_low_after_take", bus.done, 0);
        chk("mu_hold", s20(bus.mu), exp_mu);
        chk("out0_hold", s20(bus.out[0]), exp_out[0]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_flag", bus.done, bus.state == 2'b10);
            if (exp_valid && bus.state == 2'b10) begin
                chk("mu", s20(bus.mu), exp_mu);
                chk("vari", s20(bus.vari), exp_vari);
                for (int i = 0; i < SIZE; i++) begin
                    chk($sformatf("norm[%0d]", i), s20(bus.norm[i]), exp_norm[i]);
                    chk($sformatf("out[%0d]", i), s20(bus.out[i]), exp_out[i]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int lim;
        bus.input_ready  = 1'b0;
        bus.output_taken = 1'b0;
        bus.num   = '0;
        bus.gamma = '0;
        bus.beta  = '0;
        for (int i = 0; i < SIZE; i++) bus.batch[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mu", s20(bus.mu), 0);
        chk("rst_vari", s20(bus.vari), 0);
        for (int i = 0; i < SIZE; i++) begin
            chk("rst_norm", s20(bus.norm[i]), 0);
            chk("rst_out", s20(bus.out[i]), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant vector: zero variance, zero norm.
        clear_vec();
        for (int i = 0; i < 4; i++) xv[i] = 65536;
        tn = 4; tg = 65536; tbeta = 0;
        model();
        chk("m1_mu", exp_mu, 65536);
        chk("m1_norm0", exp_norm[0], 0);
        run_job(35, 1'b0, 0);
        chk("t1_mu", s20(bus.mu), 65536);
        chk("t1_vari", s20(bus.vari), 0);
        chk("t1_out3", s20(bus.out[3]), 0);
        release_job();

        // Alternating +/-1.0 with affine.
        clear_vec();
        xv[0] = 65536; xv[1] = -65536; xv[2] = 65536; xv[3] = -65536;
        tn = 4; tg = 131072; tbeta = 32768;
        model();
        chk("m2_vari", exp_vari, 65536);
        chk("m2_norm0", exp_norm[0], 65535);
        chk("m2_norm1", exp_norm[1], -65535);
        chk("m2_out0", exp_out[0], 163838);
        chk("m2_out1", exp_out[1], -98302);
        run_job(35, 1'b0, 0);
        chk("t2_out1", s20(bus.out[1]), -98302);
        chk("t2_norm2", s20(bus.norm[2]), 65535);
        release_job();

        // Saturating variance and outputs.
        clear_vec();
        xv[0] = 458752; xv[1] = -458752;
        tn = 2; tg = 524287; tbeta = 524287;
        model();
        chk("m3_vari", exp_vari, 524287);
        chk("m3_norm0", exp_norm[0], 162190);
        chk("m3_norm1", exp_norm[1], -162190);
        chk("m3_out0", exp_out[0], 524287);
        chk("m3_out1", exp_out[1], -524288);
        run_job(29, 1'b0, 0);
        chk("t3_out1", s20(bus.out[1]), -524288);
        release_job();

        // Empty vector.
        for (int i = 0; i < SIZE; i++) xv[i] = longint'($urandom_range(0, 131070)) - 65535;
        tn = 0; tg = 65536; tbeta = 4096;
        run_job(1, 1'b0, 0);
        chk("t4_norm5", s20(bus.norm[5]), 0);
        chk("t4_out0", s20(bus.out[0]), 0);
        release_job();

        // Async reset in the middle of the square-root phase, then rerun.
        clear_vec();
        xv[0] = 65536; xv[1] = -65536; xv[2] = 65536; xv[3] = -65536;
        tn = 4; tg = 131072; tbeta = 32768;
        load();
        exp_valid = 1'b0;
        bus.input_ready = 1'b1;
        @(posedge clk); #1;
        bus.input_ready = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", bus.state, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_vari", s20(bus.vari), 0);
        chk("midrst_mu", s20(bus.mu), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(35, 1'b0, 0);
        chk("t5_out0", s20(bus.out[0]), 163838);
        release_job();

        // Long hold in DONE with request toggling during BUSY.
        clear_vec();
        for (int i = 0; i < 6; i++) xv[i] = longint'($urandom_range(0, 262142)) - 131071;
        tn = 6; tg = 98304; tbeta = -16384;
        run_job(41, 1'b1, 10);
        release_job();

        for (int j = 0; j < 25; j++) begin
            tn = int'($urandom_range(0, 15));
            lim = (tn > 7) ? 65535 : 131071;
            for (int i = 0; i < SIZE; i++) xv[i] = longint'($urandom_range(0, 2 * lim)) - lim;
            tg    = longint'($urandom_range(0, 1048575)) - 524288;
            tbeta = longint'($urandom_range(0, 1048575)) - 524288;
            run_job((tn == 0) ? 1 : 3 * tn + 23, 1'(j % 2), j % 3);
            release_job();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
